fb_zoom_loader: RTL and testbench

//   Fills the VGA framebuffer (ram2port write port) from the 160x120 8-bit grayscale image ROM.

---
 rtl/fb_zoom_loader.sv | 230 +++++++++++++++++++++++
 tb/tb_fb_zoom_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fb_zoom_loader.sv
// fb_zoom_loader: copies a grayscale source image from ROM into the VGA
// framebuffer, either 1:1 or with 2x2 nearest-neighbour replication.
// A change of the mode switch aborts any copy and restarts from pixel 0.
module fb_zoom_loader #(
    parameter int IMG_W   = 160,
    parameter int IMG_H   = 120,
    parameter int ROM_LAT = 2,
    parameter int AW      = 19
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          switch,
    output logic [AW-1:0] rom_addr,
    input  logic [7:0]    rom_data,
    output logic [AW-1:0] ram_wraddr,
    output logic [7:0]    ram_data,
    output logic          ram_wren,
    output logic          busy,
    output logic          done
);

    localparam int SXW = $clog2(IMG_W);
    localparam int SYW = $clog2(IMG_H);
    localparam int CW  = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    localparam logic [AW-1:0]  W1_A      = AW'(IMG_W);
    localparam logic [AW-1:0]  W2_A      = AW'(2 * IMG_W);
    localparam logic [AW-1:0]  W4_A      = AW'(4 * IMG_W);
    localparam logic [AW-1:0]  COL1_A    = AW'(1);
    localparam logic [AW-1:0]  COL2_A    = AW'(2);
    localparam logic [SXW-1:0] SX_LAST   = SXW'(IMG_W - 1);
    localparam logic [SYW-1:0] SY_LAST   = SYW'(IMG_H - 1);
    localparam logic [CW-1:0]  WAIT_INIT = CW'(ROM_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_FETCH,
        S_WAIT,
        S_WRITE,
        S_FIN,
        S_IDLE_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic            r_sw_m;
    logic            r_sw_s;
    logic            r_sw_q;
    logic            r_f2;
    logic [SXW-1:0]  r_sx;
    logic [SYW-1:0]  r_sy;
    logic            r_dx;
    logic            r_dy;
    logic [CW-1:0]   r_wait;
    logic [AW-1:0]   r_src_base;
    logic [AW-1:0]   r_dst_base;
    logic [AW-1:0]   r_dst_col;

    logic [AW-1:0]   r_rom_addr;
    logic [AW-1:0]   r_wraddr;
    logic [7:0]      r_ram_data;
    logic            r_wren;
    logic            r_busy;
    logic            r_done;

    logic            w_sw_chg;
    logic [AW-1:0]   w_dw;
    logic [AW-1:0]   w_row_step;
    logic            w_last_sub;
    logic            w_last_px;
    logic            w_ndx;
    logic            w_ndy;
    logic [AW-1:0]   w_first_addr;
    logic [AW-1:0]   w_step_addr;

    assign rom_addr   = r_rom_addr;
    assign ram_wraddr = r_wraddr;
    assign ram_data   = r_ram_data;
    assign ram_wren   = r_wren;
    assign busy       = r_busy;
    assign done       = r_done;

    // Mode-dependent strides and the next replicated sub-write position
    always_comb begin
        w_sw_chg     = (r_sw_s != r_sw_q);
        w_dw         = r_f2 ? W2_A : W1_A;
        w_row_step   = r_f2 ? W4_A : W1_A;
        // 2x2 order is (0,0) (1,0) (0,1) (1,1): dx toggles, dy follows dx carry
        w_ndx        = ~r_dx;
        w_ndy        = r_dy ^ r_dx;
        w_last_sub   = ~r_f2 | (r_dx & r_dy);
        w_last_px    = (r_sx == SX_LAST) && (r_sy == SY_LAST);
        w_first_addr = r_dst_base + r_dst_col;
        w_step_addr  = w_first_addr + (w_ndy ? w_dw : {AW{1'b0}})
                     + {{(AW-1){1'b0}}, w_ndx};
    end

    // Next-state selection; a switch change overrides every state
    always_comb begin
        w_next = r_state;
        if (w_sw_chg) begin
            w_next = S_START;
        end else begin
            case (r_state)
                S_IDLE:      w_next = S_START;
                S_START:     w_next = S_FETCH;
                S_FETCH:     w_next = S_WAIT;
                S_WAIT:      w_next = (r_wait == {CW{1'b0}}) ? S_WRITE : S_WAIT;
                S_WRITE: begin
                    if (w_last_sub) begin
                        w_next = w_last_px ? S_FIN : S_FETCH;
                    end else begin
                        w_next = S_WRITE;
                    end
                end
                S_FIN:       w_next = S_IDLE_DONE;
                S_IDLE_DONE: w_next = S_IDLE_DONE;
                default:     w_next = S_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Switch synchroniser, scan counters, row bases and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sw_m     <= switch;
            r_sw_s     <= switch;
            r_sw_q     <= switch;
            r_f2       <= 1'b0;
            r_sx       <= {SXW{1'b0}};
            r_sy       <= {SYW{1'b0}};
            r_dx       <= 1'b0;
            r_dy       <= 1'b0;
            r_wait     <= {CW{1'b0}};
            r_src_base <= {AW{1'b0}};
            r_dst_base <= {AW{1'b0}};
            r_dst_col  <= {AW{1'b0}};
            r_rom_addr <= {AW{1'b0}};
            r_wraddr   <= {AW{1'b0}};
            r_ram_data <= 8'h00;
            r_wren     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_sw_m <= switch;
            r_sw_s <= r_sw_m;
            if (w_sw_chg) begin
                // Abort: any partial burst is dropped, copy restarts via START
                r_sw_q <= r_sw_s;
                r_wren <= 1'b0;
                r_done <= 1'b0;
                r_busy <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_busy <= 1'b1;
                    end
                    S_START: begin
                        r_f2       <= r_sw_q;
                        r_sx       <= {SXW{1'b0}};
                        r_sy       <= {SYW{1'b0}};
                        r_dx       <= 1'b0;
                        r_dy       <= 1'b0;
                        r_src_base <= {AW{1'b0}};
                        r_dst_base <= {AW{1'b0}};
                        r_dst_col  <= {AW{1'b0}};
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                    end
                    S_FETCH: begin
                        r_rom_addr <= r_src_base + AW'(r_sx);
                        r_wait     <= WAIT_INIT;
                    end
                    S_WAIT: begin
                        r_wait <= r_wait - CW'(1);
                        if (r_wait == {CW{1'b0}}) begin
                            // ROM word is valid now; present the first sub-write
                            r_ram_data <= rom_data;
                            r_wraddr   <= w_first_addr;
                            r_wren     <= 1'b1;
                            r_dx       <= 1'b0;
                            r_dy       <= 1'b0;
                        end
                    end
                    S_WRITE: begin
                        if (!w_last_sub) begin
                            r_dx     <= w_ndx;
                            r_dy     <= w_ndy;
                            r_wraddr <= w_step_addr;
                        end else begin
                            r_wren <= 1'b0;
                            if (r_sx == SX_LAST) begin
                                r_sx       <= {SXW{1'b0}};
                                r_sy       <= r_sy + SYW'(1);
                                r_src_base <= r_src_base + W1_A;
                                r_dst_base <= r_dst_base + w_row_step;
                                r_dst_col  <= {AW{1'b0}};
                            end else begin
                                r_sx      <= r_sx + SXW'(1);
                                r_dst_col <= r_dst_col + (r_f2 ? COL2_A : COL1_A);
                            end
                        end
                    end
                    S_FIN: begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end
                    S_IDLE_DONE: begin
                        r_wren <= 1'b0;
                    end
                    default: begin
                        r_wren <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fb_zoom_loader.sv
// Scoreboard bench for fb_zoom_loader on a reduced 16x12 image.
module tb_fb_zoom_loader;

    localparam int IMG_W = 16;
    localparam int IMG_H = 12;
    localparam int AW    = 19;
    localparam int NPIX  = IMG_W * IMG_H;

    logic          clk;
    logic          reset;
    logic          switch;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data;
    logic [AW-1:0] ram_wraddr;
    logic [7:0]    ram_data;
    logic          ram_wren;
    logic          busy;
    logic          done;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t sb_q[$];
    int  n_chk;
    int  n_err;
    int  n_wr;
    int  last_addr;
    int  last_data;

    fb_zoom_loader #(
        .IMG_W   (IMG_W),
        .IMG_H   (IMG_H),
        .ROM_LAT (2),
        .AW      (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .switch     (switch),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .ram_wraddr (ram_wraddr),
        .ram_data   (ram_data),
        .ram_wren   (ram_wren),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: content is the low byte of the address, registered read
    initial rom_data = 8'h00;
    always @(posedge clk) rom_data <= 8'(rom_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Replace the scoreboard with the full expected write list for one mode
    task automatic push_seq(input bit f2);
        wr_t e;
        int  f;
        int  dw;
        sb_q.delete();
        n_wr = 0;
        f  = f2 ? 2 : 1;
        dw = IMG_W * f;
        for (int sy = 0; sy < IMG_H; sy++)
            for (int sx = 0; sx < IMG_W; sx++)
                for (int dy = 0; dy < f; dy++)
                    for (int dx = 0; dx < f; dx++) begin
                        e.addr = (sy * f + dy) * dw + sx * f + dx;
                        e.data = (sy * IMG_W + sx) & 8'hFF;
                        sb_q.push_back(e);
                    end
    endtask

    // Monitor: every write must match the head of the scoreboard
    always @(negedge clk) begin
        wr_t e;
        if (ram_wren === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("extra_write_addr", ram_wraddr, 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                chk("wr_addr", ram_wraddr, e.addr);
                chk("wr_data", ram_data, e.data);
            end
            n_wr++;
            last_addr = int'(ram_wraddr);
            last_data = int'(ram_data);
        end
    end

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_rom_addr"}, rom_addr, 0);
        chk({tag, "_wraddr"}, ram_wraddr, 0);
        chk({tag, "_data"}, ram_data, 0);
        chk({tag, "_wren"}, ram_wren, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            #2;
            if (done) break;
        end
        chk("done_reached", done, 1);
    endtask

    task automatic check_finished(input string tag, input int n_exp, input int a_exp, input int d_exp);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_wren"}, ram_wren, 0);
        chk({tag, "_writes"}, n_wr, n_exp);
        chk({tag, "_sb_left"}, sb_q.size(), 0);
        chk({tag, "_last_addr"}, last_addr, a_exp);
        chk({tag, "_last_data"}, last_data, d_exp);
    endtask

    // Change the mode switch and confirm the abort reaches the outputs in 3 cycles
    task automatic toggle_restart(input bit new_sw);
        switch = new_sw;
        repeat (3) @(posedge clk);
        #2;
        chk("abort_wren_low", ram_wren, 0);
        chk("abort_done_low", done, 0);
        chk("abort_busy", busy, 1);
        push_seq(new_sw);
    endtask

    task automatic wait_writes(input int n);
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            #2;
            if (n_wr >= n && ram_wren) break;
        end
        chk("reached_writes", (n_wr >= n) ? 1 : 0, 1);
    endtask

    initial begin
        int lat;
        n_chk = 0;
        n_err = 0;
        n_wr  = 0;
        last_addr = -1;
        last_data = -1;
        switch = 1'b0;
        reset  = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #2;
        check_zero_outputs("reset");

        // Factor-1 copy with first-write latency from reset release
        push_seq(1'b0);
        reset = 1'b1;
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #2;
            if (ram_wren) begin
                lat = i;
                break;
            end
        end
        chk("first_write_latency", lat, 5);
        chk("first_write_addr", ram_wraddr, 0);
        chk("first_write_data", ram_data, 0);
        chk("busy_in_copy", busy, 1);
        wait_done(5000);
        check_finished("f1", NPIX, NPIX - 1, (NPIX - 1) & 8'hFF);

        // Done holds with a stable switch
        repeat (1000) @(posedge clk);
        #2;
        chk("hold_done", done, 1);
        chk("hold_writes", n_wr, NPIX);

        // Switch to factor 2 from the finished state
        toggle_restart(1'b1);
        wait_done(10000);
        check_finished("f2", 4 * NPIX, 4 * NPIX - 1, (NPIX - 1) & 8'hFF);

        // Back to factor 1, then 0->1 toggle mid-copy
        toggle_restart(1'b0);
        wait_writes(50);
        toggle_restart(1'b1);
        wait_done(10000);
        check_finished("abort_f2", 4 * NPIX, 4 * NPIX - 1, (NPIX - 1) & 8'hFF);

        // Reset pulse inside a write burst
        wait_writes(0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_zero_outputs("idle_rst");
        @(posedge clk);
        #2;
        push_seq(1'b1);
        reset = 1'b1;
        wait_writes(30);
        @(posedge clk);
        #2;
        chk("burst_before_rst", ram_wren, 1);
        reset = 1'b0;
        #1;
        check_zero_outputs("mid_rst");
        @(posedge clk);
        #2;
        push_seq(1'b1);
        reset = 1'b1;
        wait_done(10000);
        check_finished("rst_f2", 4 * NPIX, 4 * NPIX - 1, (NPIX - 1) & 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
